sync_fifo_v2: RTL and testbench
===============================

Name: sync_fifo_v2

Overview:
Second-generation synchronous FIFO for the P_S datapath. It generalises the first FIFO with a run-time-independent set of parameters:
- arbitrary (non-power-of-2) depth
- programmable almost-full/almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- exported occupancy count
- sticky overflow/underflow error flags with clear

It sits between producer and consumer blocks in one clock domain.

Parameters:
DATA_WIDTH, 8, width of din/dout in bits
DEPTH, 16, number of entries; any value >= 2, need not be a power of 2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop in FWFT mode)
dout  output  DATA_WIDTH  read data
dout_valid  output  1  dout holds valid data (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CNT_W  occupancy, CNT_W = $clog2(DEPTH+1)
err_clr  input  1  clears overflow/underflow
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: rst sampled on clk edge. It clears:
  - wr_ptr, rd_ptr, count to 0
  - dout to 0; dout_valid, overflow, underflow to 0

  Flags then read empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 never legal so 0). Memory contents are not reset. Reset mid-operation discards all entries on that edge.
- Validity: wr_ok = wr_en && !full; rd_ok = rd_en && !empty. Full is evaluated before the edge, so a write while full is rejected even with a concurrent read. Likewise a read while empty is rejected even with a concurrent write.
- Pointers: range 0..DEPTH-1 and wrap explicitly to 0 at DEPTH-1 (no power-of-2 reliance).
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. All status flags are combinational from count.
- Standard mode (FWFT=0):
  - On rd_ok, dout <= mem[rd_ptr] and dout_valid <= 1 for exactly one cycle (latency 1).
  - Otherwise dout holds and dout_valid <= 0.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally and dout_valid = !empty.
  - rd_ok pops the head; the next word is visible the same cycle after the edge.
  - A word written to an empty FIFO appears on dout the cycle after the write edge.
- Errors:
  - overflow <= 1 when wr_en && full.
  - underflow <= 1 when rd_en && empty.
  - err_clr clears both on the next edge; a new error event in the same cycle as err_clr wins (flag stays 1).
- Count saturation is impossible by construction; the bench asserts 0 <= count <= DEPTH.

Optional Feature:
Macro: SYNC_FIFO_WATERMARK_EN
- Defined: adds output max_level [CNT_W], the peak count since reset or err_clr.
  - Updated to count_next when count_next > max_level.
  - Reset to 0.
- Undefined: port and register absent; no other behaviour changes.

Decomposition:
- Package sync_fifo_pkg:
  - function cnt_width(depth) returning $clog2(depth+1)
  - localparam-style constants for mode encoding: FWFT_OFF=0, FWFT_ON=1
- Sub-module fifo_wrap_ptr (parameter DEPTH; ports clk, rst, inc, ptr): a wrap-at-DEPTH-1 counter, instantiated twice for wr/rd.
- Memory array, count and flags live in the top module.

Test Plan:
1. DEPTH=5, FWFT=0: write 5 words 0xA0..0xA4.
   - After the 5th write: full=1, count=5.
   - 6th write -> overflow=1, count stays 5.
   - Read 5 -> dout 0xA0..0xA4, each with a 1-cycle dout_valid pulse.
2. Wrap: DEPTH=5, write/read 12 words interleaved -> output order is exact and count never exceeds 5; pointers pass 4->0.
3. Simultaneous wr_en+rd_en:
   - At count=3: count stays 3 and data order is kept.
   - At count=0: only the write is accepted, count=1, underflow=1.
   - At count=DEPTH: only the read is accepted, count=DEPTH-1, overflow=1.
4. FWFT=1: write 0x55 into an empty FIFO -> next cycle dout=0x55, dout_valid=1. Pop -> empty=1, dout_valid=0.
5. Thresholds AF_LEVEL=4, AE_LEVEL=1, DEPTH=8, fill 0..8:
   - almost_empty=1 for count 0..1.
   - almost_full=1 for count 4..8.
6. rst asserted at count=6 with err flags set -> next cycle count=0, empty=1, overflow=underflow=0, dout=0. With SYNC_FIFO_WATERMARK_EN, max_level=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for sync_fifo_v2.
//   cnt_width(depth) : width of an occupancy counter able to hold 0..depth
//   FWFT_OFF/FWFT_ON : read-mode encodings for the FWFT parameter
package sync_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: pointer counter for a FIFO of arbitrary DEPTH.
//   clk, rst : clock and synchronous active-high reset (pointer -> 0)
//   inc      : advance the pointer by one on this edge
//   ptr      : current pointer, range 0..DEPTH-1, wraps DEPTH-1 -> 0
module fifo_wrap_ptr #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // Explicit compare against DEPTH-1 so non-power-of-2 depths wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) ptr_d = '0;
      else                            ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, standard or FWFT read mode,
// exported occupancy and sticky overflow/underflow flags.
// Optional build macro: SYNC_FIFO_WATERMARK_EN adds max_level (peak
// occupancy since reset or err_clr).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wr_en, din          : write request and data
//   rd_en               : read request (pop in FWFT mode)
//   dout, dout_valid    : read data and its qualifier
//   full, empty         : count == DEPTH / count == 0
//   almost_full/empty   : count >= AF_LEVEL / count <= AE_LEVEL
//   count               : current occupancy
//   err_clr             : clears overflow/underflow
//   overflow, underflow : sticky error flags
//   max_level           : (watermark build only) peak occupancy
//
// Handshake: a write is accepted when wr_en && !full and a read when
// rd_en && !empty, both judged on the flags before the edge, so a write
// while full or a read while empty is dropped even if the opposite
// operation happens in the same cycle. Dropped requests set the sticky
// error flags instead.
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  parameter  int FWFT       = FWFT_OFF,
  localparam int CNT_W      = cnt_width(DEPTH),
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
  ,
  output logic [CNT_W-1:0]      max_level
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .ptr (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .ptr (rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr] <= din;
  end

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // err_clr drops the flags, but an error in the same cycle re-sets them.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (wr_en && full)  overflow_d  = 1'b1;
    if (rd_en && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head of queue is always presented; the pop moves rd_ptr on the edge.
      assign dout       = mem_q[rd_ptr];
      assign dout_valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  dout_valid_q, dout_valid_d;

      always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (rd_ok) begin
          dout_d       = mem_q[rd_ptr];
          dout_valid_d = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_q       <= dout_d;
          dout_valid_q <= dout_valid_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] max_level_q, max_level_d;
  logic [CNT_W-1:0] max_base;

  // After err_clr the peak restarts from the occupancy after this edge.
  always_comb begin
    max_base    = err_clr ? '0 : max_level_q;
    max_level_d = (count_d > max_base) ? count_d : max_base;
  end

  always_ff @(posedge clk) begin
    if (rst) max_level_q <= '0;
    else     max_level_q <= max_level_d;
  end

  assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2. Three instances share one stimulus bus:
//   u_std : DEPTH=5, standard read mode (AF=3, AE=2)
//   u_fwft: DEPTH=5, first-word-fall-through
//   u_thr : DEPTH=8, AF_LEVEL=4, AE_LEVEL=1, standard read mode
// Each test resets all three and checks only the instance it targets.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] din = '0;

  always #5 clk = ~clk;

  logic [7:0] s_dout, f_dout, t_dout;
  logic       s_dv, f_dv, t_dv;
  logic       s_full, f_full, t_full;
  logic       s_empty, f_empty, t_empty;
  logic       s_af, f_af, t_af;
  logic       s_ae, f_ae, t_ae;
  logic [2:0] s_cnt, f_cnt;
  logic [3:0] t_cnt;
  logic       s_ovf, f_ovf, t_ovf;
  logic       s_unf, f_unf, t_unf;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [2:0] s_max, f_max;
  logic [3:0] t_max;
`endif

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_level(s_max)
`endif
  );

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_level(f_max)
`endif
  );

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_thr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(t_dout), .dout_valid(t_dv), .full(t_full), .empty(t_empty),
    .almost_full(t_af), .almost_empty(t_ae), .count(t_cnt),
    .err_clr(err_clr), .overflow(t_ovf), .underflow(t_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
    , .max_level(t_max)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    step();
    rst = 1'b0;
  endtask

  // Occupancy bound on every instance, sampled away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_cnt > 3'd5 || f_cnt > 3'd5 || t_cnt > 4'd8) begin
        n_fail++;
        $display("FAIL count_bound: s=%0d f=%0d t=%0d", s_cnt, f_cnt, t_cnt);
      end
    end
  end

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    logic       full, empty, dv;
    logic [7:0] dout;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, rd, clr, input logic [7:0] d, input int cnt,
                              input logic full, empty, dv, input logic [7:0] dout,
                              input logic ovf, unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = d; v.cnt = cnt;
    v.full = full; v.empty = empty; v.dv = dv; v.dout = dout;
    v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  logic [7:0] exp_q[$];

  initial begin
    logic [17:0] act_t, exp_t;
    logic [7:0]  wd;
    int          mc, written, nread, cyc;
    logic        pend;
    logic        w, r;

    // ---- reset state (u_std) ----
    do_reset();
    chk("reset_std", {s_cnt, s_full, s_empty, s_af, s_ae, s_dv, s_dout, s_ovf, s_unf},
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

    // ---- fill/overflow/drain, simultaneous ops, error clear (u_std, DEPTH=5) ----
    //              wr rd clr din   cnt full emp dv dout  ovf unf
    vecs.push_back(mk(1, 0, 0, 8'hA0, 1, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hA1, 2, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hA2, 3, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hA3, 4, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hA4, 5, 1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hA5, 5, 1, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 1, 8'hA0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 1, 8'hA1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8'hB0, 3, 0, 0, 1, 8'hA2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 1, 8'hA3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'hA4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 1, 8'hB0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 8'hB0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8'hC0, 1, 0, 0, 0, 8'hB0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 1, 8'hC0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hD0, 1, 0, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hD1, 2, 0, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hD2, 3, 0, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hD3, 4, 0, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'hD4, 5, 1, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'hE0, 4, 0, 0, 1, 8'hD0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'hF0, 5, 1, 0, 0, 8'hD0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 8'h77, 5, 1, 0, 0, 8'hD0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 5, 1, 0, 0, 8'hD0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 1, 8'hD1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 1, 8'hD2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 1, 8'hD3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'hD4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1, 1, 8'hF0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].wr; rd_en = vecs[i].rd; err_clr = vecs[i].clr; din = vecs[i].din;
      step();
      act_t = {s_cnt, s_full, s_empty, s_af, s_ae, s_dv, s_dout, s_ovf, s_unf};
      exp_t = {3'(vecs[i].cnt), vecs[i].full, vecs[i].empty,
               (vecs[i].cnt >= 3) ? 1'b1 : 1'b0, (vecs[i].cnt <= 2) ? 1'b1 : 1'b0,
               vecs[i].dv, vecs[i].dout, vecs[i].ovf, vecs[i].unf};
      chk($sformatf("vec%0d", i), 32'(act_t), 32'(exp_t));
    end
    wr_en = 0; rd_en = 0; err_clr = 0;

    // ---- wrap: 12 words interleaved through DEPTH=5 (u_std) ----
    do_reset();
    exp_q.delete();
    mc = 0; written = 0; nread = 0; cyc = 0; pend = 1'b0;
    while ((written < 12 || mc > 0 || pend) && cyc < 100) begin
      w = (written < 12) && ((cyc % 3) != 2);
      r = (cyc % 2) == 1;
      wr_en = w; rd_en = r; din = 8'h10 + 8'(written);
      // model: both decisions use occupancy before the edge
      if (r && mc > 0) begin
        wd = exp_q.pop_front();
        pend = 1'b1;
      end else begin
        pend = 1'b0;
      end
      if (w && mc < 5) begin
        exp_q.push_back(8'h10 + 8'(written));
        written++;
      end
      mc = exp_q.size();
      step();
      chk("wrap_count", 32'(s_cnt), 32'(mc));
      if (pend) begin
        chk("wrap_data", {23'd0, s_dv, s_dout}, {23'd0, 1'b1, wd});
        nread++;
      end else begin
        chk("wrap_idle_dv", 32'(s_dv), 32'd0);
      end
      cyc++;
    end
    wr_en = 0; rd_en = 0;
    chk("wrap_total_read", 32'(nread), 32'd12);

    // ---- FWFT (u_fwft) ----
    do_reset();
    chk("fwft_reset", {30'd0, f_dv, f_empty}, {30'd0, 1'b0, 1'b1});
    wr_en = 1; din = 8'h55;
    step();
    chk("fwft_first", {23'd0, f_dv, f_dout}, {23'd0, 1'b1, 8'h55});
    din = 8'h66;
    step();
    wr_en = 0;
    chk("fwft_head_held", {20'd0, f_cnt, f_dv, f_dout}, {20'd0, 3'd2, 1'b1, 8'h55});
    rd_en = 1;
    step();
    chk("fwft_pop_next", {23'd0, f_dv, f_dout}, {23'd0, 1'b1, 8'h66});
    step();
    rd_en = 0;
    chk("fwft_pop_empty", {30'd0, f_dv, f_empty}, {30'd0, 1'b0, 1'b1});

    // ---- thresholds and reset mid-operation (u_thr, DEPTH=8) ----
    do_reset();
    rd_en = 1;
    step();
    rd_en = 0;
    chk("thr_underflow", 32'(t_unf), 32'd1);
    for (int n = 0; n <= 8; n++) begin
      chk($sformatf("thr_level%0d", n), {26'd0, t_cnt, t_ae, t_af},
          {26'd0, 4'(n), (n <= 1) ? 1'b1 : 1'b0, (n >= 4) ? 1'b1 : 1'b0});
      if (n < 8) begin
        wr_en = 1; din = 8'(n);
        step();
      end
    end
    wr_en = 1; din = 8'hEE;
    step();
    wr_en = 0;
    chk("thr_overflow", {30'd0, t_full, t_ovf}, {30'd0, 1'b1, 1'b1});
    rd_en = 1;
    step();
    step();
    rd_en = 0;
    chk("thr_before_rst", {17'd0, t_cnt, t_dout, t_ovf, t_unf, t_dv},
        {17'd0, 4'd6, 8'h01, 1'b1, 1'b1, 1'b1});
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("thr_max_level", 32'(t_max), 32'd8);
`endif
    rst = 1;
    step();
    rst = 0;
    chk("thr_after_rst", {16'd0, t_cnt, t_empty, t_ovf, t_unf, t_dv, t_dout},
        {16'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
`ifdef SYNC_FIFO_WATERMARK_EN
    chk("thr_max_after_rst", 32'(t_max), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
